// File: rtl/ec_pkg.sv
// Shared sign-code constants and FSM state type for the error-correcting digit path.
package ec_pkg;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b10;
  localparam logic [1:0] SGN_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ec_sign_enc.sv
// Combinational two's-complement digit to 2-bit sign code; zero latency, no handshake.
import ec_pkg::*;

module ec_sign_enc #(
  parameter int DIG_W = 8
) (
  input  logic [DIG_W-1:0] dig,
  output logic [1:0]       code
);

  always_comb begin
    if (dig == '0) begin
      code = SGN_ZERO;
    end else if (dig[DIG_W-1]) begin
      code = SGN_NEG;
    end else begin
      code = SGN_POS;
    end
  end

endmodule

// File: rtl/ec_gen_sign_tx.sv
// Captures redundant A/B digit words and streams per-digit sign codes, first digit one cycle
// after the capture cycle; outputs are registered and hold while out_ready is low.
import ec_pkg::*;

module ec_gen_sign_tx #(
  parameter int NUM_DIG = 8,
  parameter int DIG_W   = 8,
  parameter int IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_DIG*DIG_W-1:0] dig_vec_A,
  input  logic [NUM_DIG*DIG_W-1:0] dig_vec_B,
  input  logic                     inj_en,
  input  logic [IDX_W-1:0]         inj_idx,
  input  logic                     out_ready,
  output logic                     sign_valid,
  output logic [1:0]               sign_out_A,
  output logic [1:0]               sign_out_B,
  output logic [IDX_W-1:0]         sign_idx,
  output logic                     sign_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

  state_t                     state, state_n;
  logic [NUM_DIG*DIG_W-1:0]   cap_a, cap_b;
  logic                       cap_inj_en;
  logic [IDX_W-1:0]           cap_inj_idx;
  logic [IDX_W-1:0]           idx_n;
  logic                       load;
  logic                       xfer_last;
  logic [DIG_W-1:0]           dig_a, dig_b;
  logic [1:0]                 code_a, code_b;
  logic                       inj_hit;

  // SEND first spends one cycle registering digit 0 from the captured copies
  always_comb begin
    state_n   = state;
    idx_n     = '0;
    load      = 1'b0;
    xfer_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SEND;
      end
      SEND: begin
        if (!sign_valid) begin
          load = 1'b1;
        end else if (out_ready) begin
          if (sign_last) begin
            xfer_last = 1'b1;
            state_n   = DONE;
          end else begin
            load  = 1'b1;
            idx_n = sign_idx + IDX_W'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_n == IDX_W'(i)) begin
        dig_a = cap_a[i*DIG_W +: DIG_W];
        dig_b = cap_b[i*DIG_W +: DIG_W];
      end
    end
  end

  ec_sign_enc #(.DIG_W(DIG_W)) u_enc_a (.dig(dig_a), .code(code_a));
  ec_sign_enc #(.DIG_W(DIG_W)) u_enc_b (.dig(dig_b), .code(code_b));

  // an out-of-range inj_idx can never equal a live digit index, so it corrupts nothing
  assign inj_hit = cap_inj_en && (cap_inj_idx == idx_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_inj_en  <= 1'b0;
      cap_inj_idx <= '0;
      sign_valid  <= 1'b0;
      sign_out_A  <= '0;
      sign_out_B  <= '0;
      sign_idx    <= '0;
      sign_last   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      if (state == IDLE && start) begin
        cap_a       <= dig_vec_A;
        cap_b       <= dig_vec_B;
        cap_inj_en  <= inj_en;
        cap_inj_idx <= inj_idx;
      end
      if (load) begin
        sign_valid <= 1'b1;
        sign_out_A <= code_a;
        sign_out_B <= inj_hit ? (code_b ^ SGN_ILL) : code_b;
        sign_idx   <= idx_n;
        sign_last  <= (idx_n == LAST_IDX);
      end else if (xfer_last) begin
        sign_valid <= 1'b0;
        sign_out_A <= '0;
        sign_out_B <= '0;
        sign_idx   <= '0;
        sign_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ec_gen_sign_tx.sv
// Bench for ec_gen_sign_tx: queue-based reference model checked every cycle, plus directed literals.
module tb_ec_gen_sign_tx;

  localparam int ND = 8;
  localparam int DW = 8;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ND*DW-1:0] dig_vec_A = '0;
  logic [ND*DW-1:0] dig_vec_B = '0;
  logic             inj_en = 1'b0;
  logic [IW-1:0]    inj_idx = '0;
  logic             out_ready = 1'b0;
  logic             sign_valid, sign_last, busy, done;
  logic [1:0]       sign_out_A, sign_out_B;
  logic [IW-1:0]    sign_idx;

  ec_gen_sign_tx #(.NUM_DIG(ND), .DIG_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dig_vec_A(dig_vec_A), .dig_vec_B(dig_vec_B),
    .inj_en(inj_en), .inj_idx(inj_idx), .out_ready(out_ready),
    .sign_valid(sign_valid), .sign_out_A(sign_out_A), .sign_out_B(sign_out_B),
    .sign_idx(sign_idx), .sign_last(sign_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] BASIC     [ND] = '{8'h00, 8'h05, 8'hFB, 8'h7F, 8'h80, 8'h01, 8'h00, 8'hFF};
  logic [1:0] EXP_BASIC [ND] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_code(input logic [7:0] d);
    if (d == 8'h00) return 2'b00;
    if ($signed(d) < 0) return 2'b10;
    return 2'b01;
  endfunction

  // Reference: a word becomes a queue of expected digits; one idle cycle before the first
  logic [1:0] q_a[$], q_b[$];
  int         q_i[$];
  bit         m_prime, m_done;
  logic [1:0] m_bc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a.delete(); q_b.delete(); q_i.delete();
      m_prime = 0; m_done = 0;
    end else if (q_a.size() != 0) begin
      m_done = 0;
      if (m_prime) begin
        m_prime = 0;
      end else if (out_ready) begin
        q_a.delete(0); q_b.delete(0); q_i.delete(0);
        if (q_a.size() == 0) m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      for (int i = 0; i < ND; i++) begin
        q_a.push_back(ref_code(dig_vec_A[i*DW +: DW]));
        m_bc = ref_code(dig_vec_B[i*DW +: DW]);
        if (inj_en && int'(inj_idx) == i) m_bc = ~m_bc;
        q_b.push_back(m_bc);
        q_i.push_back(i);
      end
      m_prime = 1;
    end
  end

  bit         ev, pv, pr;
  logic [1:0] h_a, h_b;
  logic [IW-1:0] h_i;
  int         vcnt, done_cnt, first_cyc;
  logic [1:0] ob_a[$], ob_b[$];
  int         ob_i[$];
  bit         ob_l[$];

  always @(negedge clk) begin
    ev = (q_a.size() != 0) && !m_prime;
    chk("valid", sign_valid, ev);
    chk("busy", busy, (q_a.size() != 0) || m_done);
    chk("done", done, m_done);
    if (ev) begin
      chk("code_A", sign_out_A, q_a[0]);
      chk("code_B", sign_out_B, q_b[0]);
      chk("idx", sign_idx, q_i[0]);
      chk("last", sign_last, q_i[0] == ND - 1);
    end else begin
      chk("last_idle", sign_last, 0);
    end
    if (rst_n && pv && !pr && sign_valid) begin
      chk("hold_A", sign_out_A, h_a);
      chk("hold_B", sign_out_B, h_b);
      chk("hold_idx", sign_idx, h_i);
    end
    if (sign_valid) begin
      vcnt++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (sign_valid && out_ready) begin
      ob_a.push_back(sign_out_A); ob_b.push_back(sign_out_B);
      ob_i.push_back(int'(sign_idx)); ob_l.push_back(sign_last);
    end
    if (done) done_cnt++;
    pv = sign_valid; pr = out_ready;
    h_a = sign_out_A; h_b = sign_out_B; h_i = sign_idx;
  end

  function automatic logic [ND*DW-1:0] pack_basic();
    logic [ND*DW-1:0] v;
    for (int i = 0; i < ND; i++) v[i*DW +: DW] = BASIC[i];
    return v;
  endfunction

  function automatic logic [ND*DW-1:0] rvec();
    logic [ND*DW-1:0] v;
    for (int i = 0; i < ND; i++) begin
      case ($urandom_range(0, 4))
        0:       v[i*DW +: DW] = 8'h00;
        1:       v[i*DW +: DW] = 8'h80;
        2:       v[i*DW +: DW] = 8'h7F;
        3:       v[i*DW +: DW] = 8'hFF;
        default: v[i*DW +: DW] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic start_word(input logic [ND*DW-1:0] a, input logic [ND*DW-1:0] b,
                            input logic en, input logic [IW-1:0] ix, output int n);
    @(posedge clk); #1;
    ob_a.delete(); ob_b.delete(); ob_i.delete(); ob_l.delete();
    vcnt = 0; first_cyc = -1;
    dig_vec_A = a; dig_vec_B = b; inj_en = en; inj_idx = ix; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = cyc;
    // scramble inputs so any reliance on live inputs after capture shows up
    dig_vec_A = rvec(); dig_vec_B = rvec(); inj_en = 1'($urandom); inj_idx = IW'($urandom);
  endtask

  task automatic wait_done(input int bound, output int d);
    d = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d = cyc;
        return;
      end
    end
    n_chk++; n_err++;
    $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
  endtask

  task automatic wait_idx(input int ix);
    for (int k = 0; k < 30; k++) begin
      if (sign_valid && int'(sign_idx) == ix) return;
      @(posedge clk); #1;
    end
    n_chk++; n_err++;
    $display("FAIL idx_timeout: got no idx %0d expected idx %0d", ix, ix);
  endtask

  task automatic check_obs(input string tag, input int inj_i, input int mis_i);
    logic [1:0] eb;
    chk({tag, "_count"}, ob_a.size(), ND);
    for (int i = 0; i < ND && i < ob_a.size(); i++) begin
      eb = EXP_BASIC[i];
      if (i == inj_i) eb = ~eb;
      if (i == mis_i) eb = 2'b00;
      chk($sformatf("%s_idx%0d", tag, i), ob_i[i], i);
      chk($sformatf("%s_A%0d", tag, i), ob_a[i], EXP_BASIC[i]);
      chk($sformatf("%s_B%0d", tag, i), ob_b[i], eb);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, d, dc;
    logic [ND*DW-1:0] vb, vm;
    vb = pack_basic();
    repeat (2) @(negedge clk);
    chk("rst_valid", sign_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_A", sign_out_A, 0);
    chk("rst_B", sign_out_B, 0);
    chk("rst_idx", sign_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    start_word(vb, vb, 1'b0, '0, n);
    wait_done(40, d);
    chk("basic_first_valid", first_cyc, n + 1);
    chk("basic_done_cyc", d, n + 9);
    chk("basic_valid_cycles", vcnt, 8);
    check_obs("basic", -1, -1);
    chk("basic_last7", ob_l[7], 1);
    chk("basic_last6", ob_l[6], 0);

    start_word(vb, vb, 1'b0, '0, n);
    wait_idx(2);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(40, d);
    chk("bp_valid_cycles", vcnt, 11);
    chk("bp_done_cyc", d, n + 12);
    check_obs("bp", -1, -1);

    start_word(vb, vb, 1'b1, IW'(4), n);
    wait_done(40, d);
    check_obs("inj", 4, -1);
    chk("inj_A4_lit", ob_a[4], 2'b10);
    chk("inj_B4_lit", ob_b[4], 2'b01);

    vm = vb;
    vm[1*DW +: DW] = 8'h00;
    start_word(vb, vm, 1'b1, IW'(9), n);
    wait_done(40, d);
    check_obs("mis", -1, 1);

    start_word(vb, vb, 1'b0, '0, n);
    wait_idx(5);
    start = 1'b1; dig_vec_A = rvec(); dig_vec_B = rvec(); inj_en = 1'b1; inj_idx = '0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, d);
    chk("busy_start_done_cyc", d, n + 9);
    check_obs("busy_start", -1, -1);
    start_word(vb, vb, 1'b0, '0, n2);
    chk("b2b_start_edge", n2, d + 2);
    wait_done(40, d);
    chk("b2b_first_valid", first_cyc, n2 + 1);
    check_obs("b2b", -1, -1);

    start_word(vb, vb, 1'b0, '0, n);
    wait_idx(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", sign_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_A", sign_out_A, 0);
    chk("mid_rst_B", sign_out_B, 0);
    chk("mid_rst_idx", sign_idx, 0);
    chk("mid_rst_last", sign_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_no_done", done_cnt, dc);
    chk("post_rst_idle", busy, 0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 5) == 0);
      dig_vec_A = rvec();
      if ($urandom_range(0, 1) == 1) begin
        dig_vec_B = dig_vec_A;
      end else begin
        dig_vec_B = dig_vec_A;
        dig_vec_B[$urandom_range(0, ND - 1)*DW +: DW] = 8'($urandom);
      end
      inj_en  = 1'($urandom);
      inj_idx = IW'($urandom_range(0, 15));
      rst_n   = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
